// File: rtl/alu_phase_sched.sv
// ============================================================================
// Module : alu_phase_sched
// Brief  : Sequences one operation at a time through the adiabatic ALU slice,
//          generating the four-phase power clocks and a valid/ready result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_phase_sched #(
    parameter int WIDTH       = 16,
    parameter int PHASE_TICKS = 4,
    parameter int STAGES      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic [3:0]       dp_sel,
    input  logic [WIDTH-1:0] dp_res,
    output logic             clkpos1,
    output logic             clkpos2,
    output logic             clkneg1,
    output logic             clkneg2,
    output logic             busy,
    output logic [15:0]      op_count
);

    // Counter widths are clamped to one bit so the minimal configuration stays legal.
    localparam int c_TICK_W   = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam int c_PERIOD_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [c_TICK_W-1:0]   c_TICK_LAST   = c_TICK_W'(PHASE_TICKS - 1);
    localparam logic [c_PERIOD_W-1:0] c_PERIOD_LAST = c_PERIOD_W'(STAGES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EVAL = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [c_TICK_W-1:0]   r_tick;
    logic [1:0]            r_q;
    logic [c_PERIOD_W-1:0] r_period;
    logic                  r_clkpos1;
    logic                  r_clkpos2;
    logic [WIDTH-1:0]      r_dp_a;
    logic [WIDTH-1:0]      r_dp_b;
    logic [3:0]            r_dp_sel;
    logic [WIDTH-1:0]      r_out_res;
    logic                  r_out_valid;
    logic [15:0]           r_op_count;

    logic [1:0]            w_state_nxt;
    logic [c_TICK_W-1:0]   w_tick_nxt;
    logic [1:0]            w_q_nxt;
    logic [c_PERIOD_W-1:0] w_period_nxt;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_capture;
    logic                  w_release;
    logic                  w_clkpos1_nxt;
    logic                  w_clkpos2_nxt;
    logic [3:0]            w_sel_onehot;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_tick    <= '0;
            r_q       <= 2'd0;
            r_period  <= '0;
            r_clkpos1 <= 1'b0;
            r_clkpos2 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_q       <= w_q_nxt;
            r_period  <= w_period_nxt;
            r_clkpos1 <= w_clkpos1_nxt;
            r_clkpos2 <= w_clkpos2_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    assign w_last = (r_tick == c_TICK_LAST) && (r_q == 2'd3) && (r_period == c_PERIOD_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick;
        w_q_nxt      = r_q;
        w_period_nxt = r_period;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = c_EVAL;
                    w_tick_nxt   = '0;
                    w_q_nxt      = 2'd0;
                    w_period_nxt = '0;
                end
            end
            c_EVAL: begin
                if (w_last) begin
                    w_state_nxt  = c_DONE;
                    w_tick_nxt   = '0;
                    w_q_nxt      = 2'd0;
                    w_period_nxt = '0;
                end else if (r_tick == c_TICK_LAST) begin
                    w_tick_nxt = '0;
                    w_q_nxt    = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        w_period_nxt = r_period + c_PERIOD_W'(1);
                    end
                end else begin
                    w_tick_nxt = r_tick + c_TICK_W'(1);
                end
            end
            c_DONE: begin
                if (w_accept) begin
                    w_state_nxt  = c_EVAL;
                    w_tick_nxt   = '0;
                    w_q_nxt      = 2'd0;
                    w_period_nxt = '0;
                end else if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt  = c_IDLE;
                w_tick_nxt   = '0;
                w_q_nxt      = 2'd0;
                w_period_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_ready   = (r_state == c_IDLE) || ((r_state == c_DONE) && out_ready);
        w_accept     = in_valid && w_in_ready;
        w_capture    = (r_state == c_EVAL) && w_last;
        w_release    = (r_state == c_DONE) && out_ready;
        w_sel_onehot = 4'b0001 << in_op;
        // Phases follow the quarter the slice will be in after this edge.
        w_clkpos1_nxt = (w_state_nxt == c_EVAL) && ((w_q_nxt == 2'd0) || (w_q_nxt == 2'd1));
        w_clkpos2_nxt = (w_state_nxt == c_EVAL) && ((w_q_nxt == 2'd1) || (w_q_nxt == 2'd2));
    end

    // ------------------------------------------------------------------------
    // Operand, select and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_dp_sel    <= 4'b0000;
            r_out_res   <= '0;
            r_out_valid <= 1'b0;
            r_op_count  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_dp_a   <= in_a;
                r_dp_b   <= in_b;
                r_dp_sel <= w_sel_onehot;
            end else if (w_capture) begin
                r_dp_sel <= 4'b0000;
            end

            if (w_capture) begin
                r_out_res   <= dp_res;
                r_out_valid <= 1'b1;
                if (r_op_count != 16'hFFFF) begin
                    r_op_count <= r_op_count + 16'd1;
                end
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign dp_a      = r_dp_a;
    assign dp_b      = r_dp_b;
    assign dp_sel    = r_dp_sel;
    assign clkpos1   = r_clkpos1;
    assign clkpos2   = r_clkpos2;
    assign clkneg1   = ~r_clkpos1;
    assign clkneg2   = ~r_clkpos2;
    assign busy      = (r_state == c_EVAL);
    assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_phase_sched.sv
// ============================================================================
// Module : tb_alu_phase_sched
// Brief  : Self-checking bench for alu_phase_sched (default and minimal configs).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_phase_sched;

    localparam int D_PT  = 4;
    localparam int D_ST  = 2;
    localparam int D_LAT = D_ST * 4 * D_PT;
    localparam int M_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a, in_b, out_res, dp_a, dp_b, dp_res, op_count;
    logic [3:0]  dp_sel;
    logic        clkpos1, clkpos2, clkneg1, clkneg2, busy;

    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [1:0]  m_in_op;
    logic [15:0] m_in_a, m_in_b, m_out_res, m_dp_a, m_dp_b, m_dp_res, m_op_count;
    logic [3:0]  m_dp_sel;
    logic        m_clkpos1, m_clkpos2, m_clkneg1, m_clkneg2, m_busy;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    int m_exp_cnt = 0;

    always #5 clk = ~clk;

    // Behavioural ALU slice: lanes OR-ed together so a bad select shows up.
    function automatic logic [15:0] slice(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = '0;
        if (sel[0]) r = r | (a ^ b);
        if (sel[1]) r = r | (a & b);
        if (sel[2]) r = r | (a | b);
        if (sel[3]) r = r | 16'((32'(a) + 32'(b)) % 65536);
        return r;
    endfunction

    function automatic logic [15:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            0:       return a ^ b;
            1:       return a & b;
            2:       return a | b;
            default: return 16'((int'(a) + int'(b)) % 65536);
        endcase
    endfunction

    assign dp_res   = slice(dp_sel, dp_a, dp_b);
    assign m_dp_res = slice(m_dp_sel, m_dp_a, m_dp_b);

    alu_phase_sched #(.WIDTH(16), .PHASE_TICKS(D_PT), .STAGES(D_ST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_res(dp_res),
        .clkpos1(clkpos1), .clkpos2(clkpos2), .clkneg1(clkneg1), .clkneg2(clkneg2),
        .busy(busy), .op_count(op_count)
    );

    alu_phase_sched #(.WIDTH(16), .PHASE_TICKS(1), .STAGES(1)) dut_min (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_op(m_in_op), .in_a(m_in_a), .in_b(m_in_b),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_res(m_out_res),
        .dp_a(m_dp_a), .dp_b(m_dp_b), .dp_sel(m_dp_sel), .dp_res(m_dp_res),
        .clkpos1(m_clkpos1), .clkpos2(m_clkpos2), .clkneg1(m_clkneg1), .clkneg2(m_clkneg2),
        .busy(m_busy), .op_count(m_op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_dp_b", dp_b, 0);
        chk("rst_dp_sel", dp_sel, 0);
        chk("rst_clkpos", {clkpos1, clkpos2}, 0);
        chk("rst_clkneg", {clkneg1, clkneg2}, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_m_out_valid", m_out_valid, 0);
        chk("rst_m_op_count", m_op_count, 0);
    endtask

    // Issue one request and follow it through EVAL; leaves the DUT holding its result.
    task automatic run_op(input int op, input logic [15:0] a, input logic [15:0] b, input int stall);
        int guard;
        int qtr;
        logic [15:0] exp_res;
        exp_res  = ref_alu(op, a, b);
        in_op    = 2'(op);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        chk("accept_wait", guard < 100, 1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 16'($urandom);
        in_b      = 16'($urandom);
        in_op     = 2'($urandom_range(0, 3));
        exp_cnt   = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
        chk("valid_drop_on_accept", out_valid, 0);
        for (int cyc = 0; cyc < D_LAT; cyc++) begin
            qtr = (cyc / D_PT) % 4;
            chk("eval_busy", busy, 1);
            chk("eval_out_valid", out_valid, 0);
            chk("eval_in_ready", in_ready, 0);
            chk("eval_clkpos1", clkpos1, qtr < 2);
            chk("eval_clkpos2", clkpos2, qtr == 1 || qtr == 2);
            chk("eval_clkneg1", clkneg1, !(qtr < 2));
            chk("eval_clkneg2", clkneg2, !(qtr == 1 || qtr == 2));
            chk("eval_dp_sel", dp_sel, 32'(1) << op);
            chk("eval_dp_a", dp_a, a);
            chk("eval_dp_b", dp_b, b);
            step();
        end
        chk("done_out_valid", out_valid, 1);
        chk("done_out_res", out_res, exp_res);
        chk("done_op_count", op_count, exp_cnt);
        chk("done_busy", busy, 0);
        chk("done_clkpos", {clkpos1, clkpos2}, 0);
        chk("done_clkneg", {clkneg1, clkneg2}, 2'b11);
        chk("done_dp_sel", dp_sel, 0);
        chk("done_in_ready", in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            step();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_res", out_res, exp_res);
            chk("bp_dp_a", dp_a, a);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 0);
            chk("bp_clkpos", {clkpos1, clkpos2}, 0);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", in_ready, 1);
        step();
        chk("drain_out_valid", out_valid, 0);
        chk("drain_busy", busy, 0);
        out_ready = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
    endtask

    task automatic run_min(input int op, input logic [15:0] a, input logic [15:0] b);
        int qtr;
        m_in_op     = 2'(op);
        m_in_a      = a;
        m_in_b      = b;
        m_in_valid  = 1'b1;
        m_out_ready = 1'b0;
        chk("min_in_ready", m_in_ready, 1);
        step();
        m_in_valid = 1'b0;
        m_exp_cnt++;
        for (int cyc = 0; cyc < M_LAT; cyc++) begin
            qtr = cyc % 4;
            chk("min_busy", m_busy, 1);
            chk("min_out_valid", m_out_valid, 0);
            chk("min_clkpos1", m_clkpos1, qtr < 2);
            chk("min_clkpos2", m_clkpos2, qtr == 1 || qtr == 2);
            chk("min_clkneg1", m_clkneg1, !(qtr < 2));
            step();
        end
        chk("min_out_valid_rise", m_out_valid, 1);
        chk("min_out_res", m_out_res, ref_alu(op, a, b));
        chk("min_op_count", m_op_count, m_exp_cnt);
        chk("min_clkpos_done", {m_clkpos1, m_clkpos2}, 0);
        m_out_ready = 1'b1;
        step();
        chk("min_drain", m_out_valid, 0);
        m_out_ready = 1'b0;
    endtask

    initial begin
        bit pending;
        in_valid = 1'b0; out_ready = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0;
        m_in_valid = 1'b0; m_out_ready = 1'b0; m_in_op = 2'd0; m_in_a = '0; m_in_b = '0;

        #2 rst = 1'b1;
        #1 chk_reset();
        @(negedge clk) rst = 1'b0;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // XOR with 10 cycles of backpressure
        run_op(0, 16'hA5A5, 16'hFFFF, 10);
        drain();

        // Add followed by a back-to-back AND accepted on the release edge
        run_op(3, 16'h0001, 16'h0002, 0);
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        run_op(1, 16'h0F0F, 16'h3C3C, 2);
        drain();

        // Randomized requests, mixing drains and back-to-back issue
        pending = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pending) begin
                out_ready = 1'b1;
                #1;
            end
            run_op($urandom_range(0, 3), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
            pending = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                drain();
                pending = 1'b0;
            end
        end
        if (pending) drain();

        // Reset asserted ten edges into EVAL, between clock edges
        in_op = 2'd2; in_a = 16'h1234; in_b = 16'h4321; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1 chk_reset();
        exp_cnt = 0;
        m_exp_cnt = 0;
        @(negedge clk) rst = 1'b0;
        step();
        chk("rel_in_ready", in_ready, 1);
        chk("rel_op_count", op_count, 0);
        chk("rel_busy", busy, 0);
        run_op(2, 16'h00F0, 16'h0F00, 1);
        drain();

        // Minimal configuration: one clk per quarter, one period
        run_min(3, 16'hFFFF, 16'h0002);
        run_min(0, 16'h1357, 16'h2468);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
